// File: rtl/block_assembler.sv
// block_assembler
// ---------------------------------------------------------------------------
// Turns a block-raster pixel stream (M*M pixels per block, blocks left to
// right and then top to bottom) into raster write addresses (row*N + col) for
// an N x N result frame buffer. It also counts blocks, flags stream and
// configuration errors, and reports frame completion.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   cfg_load    one-cycle strobe, latches img_n/blk_m (accepted in IDLE/FULL)
//   img_n       image side N in pixels
//   blk_m       block side M in pixels (N must be a multiple of M, M >= 1)
//   Pixel_Data  blended pixel from upstream
//   new_pixel   pixel strobe, one rising edge per pixel
//   done        upstream end-of-block level, sampled on the rising edge
//   wr_en       frame buffer write strobe (one cycle per pixel)
//   wr_addr     raster write address
//   wr_data     pixel to write
//   blk_done    pulses with the write of the last pixel of each block
//   frame_done  level, set once every block is written, cleared by cfg_load
//   err         sticky error flag, cleared by reset or cfg_load
//   dbg_state   current FSM state (0 IDLE, 1 SETUP, 2 RUN, 3 FULL)
//
// Handshake: there is no back-pressure. A pixel is transferred on every
// rising edge where new_pixel is high and the FSM is in RUN. Its write
// appears on wr_en/wr_addr/wr_data exactly one cycle later. The frame buffer
// must accept one write per cycle.
// ---------------------------------------------------------------------------
module block_assembler #(
    parameter int Data_Depth    = 8,
    parameter int Max_Img_Width = 720,
    parameter int Addr_Width    = 19,
    parameter int Dim_Width     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [Dim_Width-1:0]  img_n,
    input  logic [Dim_Width-1:0]  blk_m,
    input  logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  new_pixel,
    input  logic                  done,
    output logic                  wr_en,
    output logic [Addr_Width-1:0] wr_addr,
    output logic [Data_Depth-1:0] wr_data,
    output logic                  blk_done,
    output logic                  frame_done,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    // Frames larger than the address space are rejected during setup.
    localparam logic [2*Dim_Width:0] ADDR_SPAN = (2*Dim_Width+1)'(1) << Addr_Width;

    state_t state, state_nx;

    logic [Dim_Width-1:0]  n_reg, m_reg;
    logic [Dim_Width-1:0]  rem, quot;       // iterative N/M divide
    logic [Dim_Width-1:0]  bpr_last;        // N/M - 1
    logic [Addr_Width-1:0] row_skip;        // N*(M-1)
    logic [Dim_Width-1:0]  c, r, bc, br;
    logic [Addr_Width-1:0] line_addr, blk_base;
    logic                  blk_seen;        // at least one block completed

    // Setup-only arithmetic. The multiplies are off the per-pixel path and
    // are sampled once, when the divide finishes.
    logic [2*Dim_Width-1:0] n_sq, n_skip;
    logic [Addr_Width-1:0]  n_ext, m_ext;
    logic                   div_done, cfg_bad;

    // Per-pixel decode.
    logic                  end_row, end_blk, last_bc, last_br, pix_run, frame_end;
    logic [Dim_Width-1:0]  c_post, r_post;
    logic                  blk_seen_post, done_ok;
    logic [Addr_Width-1:0] blk_base_nx;

    assign dbg_state = state;

    always_comb begin
        n_ext    = {{(Addr_Width-Dim_Width){1'b0}}, n_reg};
        m_ext    = {{(Addr_Width-Dim_Width){1'b0}}, m_reg};
        n_sq     = {{Dim_Width{1'b0}}, n_reg} * {{Dim_Width{1'b0}}, n_reg};
        n_skip   = {{Dim_Width{1'b0}}, n_reg} * {{Dim_Width{1'b0}}, m_reg - 1'b1};
        div_done = (m_reg == '0) || (rem < m_reg);
        cfg_bad  = (m_reg == '0) || (n_reg == '0) || (rem != '0) ||
                   ({1'b0, n_sq} > ADDR_SPAN);

        end_row   = (c == m_reg - 1'b1);
        end_blk   = end_row && (r == m_reg - 1'b1);
        last_bc   = (bc == bpr_last);
        last_br   = (br == bpr_last);
        pix_run   = (state == S_RUN) && new_pixel;
        frame_end = pix_run && end_blk && last_bc && last_br;

        // Counters as they will be after this edge; the done check uses them
        // so a pixel arriving with done is accounted for first.
        c_post        = c;
        r_post        = r;
        blk_seen_post = blk_seen;
        if (pix_run) begin
            c_post = end_row ? '0 : c + 1'b1;
            if (end_row) begin
                r_post = end_blk ? '0 : r + 1'b1;
            end
            if (end_blk) begin
                blk_seen_post = 1'b1;
            end
        end
        done_ok = (c_post == '0) && (r_post == '0) && blk_seen_post;

        // Next block origin: step right by M, or wrap to the next block row.
        blk_base_nx = last_bc ? blk_base + row_skip + m_ext : blk_base + m_ext;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cfg_load) state_nx = S_SETUP;
            S_SETUP: if (div_done) state_nx = cfg_bad ? S_IDLE : S_RUN;
            S_RUN:   if (frame_end) state_nx = S_FULL;
            S_FULL:  if (cfg_load) state_nx = S_SETUP;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            blk_done   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            n_reg      <= '0;
            m_reg      <= '0;
            rem        <= '0;
            quot       <= '0;
            bpr_last   <= '0;
            row_skip   <= '0;
            c          <= '0;
            r          <= '0;
            bc         <= '0;
            br         <= '0;
            line_addr  <= '0;
            blk_base   <= '0;
            blk_seen   <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            blk_done <= 1'b0;
            case (state)
                S_IDLE, S_FULL: begin
                    if (cfg_load) begin
                        n_reg      <= img_n;
                        m_reg      <= blk_m;
                        rem        <= img_n;
                        quot       <= '0;
                        err        <= 1'b0;
                        frame_done <= 1'b0;
                    end else if (state == S_FULL && new_pixel) begin
                        err <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (new_pixel) begin
                        err <= 1'b1;
                    end
                    if (!div_done) begin
                        rem  <= rem - m_reg;
                        quot <= quot + 1'b1;
                    end else begin
                        bpr_last  <= quot - 1'b1;
                        row_skip  <= n_skip[Addr_Width-1:0];
                        c         <= '0;
                        r         <= '0;
                        bc        <= '0;
                        br        <= '0;
                        line_addr <= '0;
                        blk_base  <= '0;
                        blk_seen  <= 1'b0;
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (new_pixel) begin
                        wr_en   <= 1'b1;
                        wr_data <= Pixel_Data;
                        wr_addr <= line_addr + {{(Addr_Width-Dim_Width){1'b0}}, c};
                        c       <= c_post;
                        r       <= r_post;
                        if (end_blk) begin
                            blk_done  <= 1'b1;
                            blk_seen  <= 1'b1;
                            blk_base  <= blk_base_nx;
                            line_addr <= blk_base_nx;
                            if (last_bc) begin
                                bc <= '0;
                                br <= br + 1'b1;
                                if (last_br) begin
                                    frame_done <= 1'b1;
                                end
                            end else begin
                                bc <= bc + 1'b1;
                            end
                        end else if (end_row) begin
                            line_addr <= line_addr + n_ext;
                        end
                    end
                    // Counters are not resynchronised on a misplaced done.
                    if (done && !done_ok) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_assembler.sv
module tb_block_assembler;

    localparam int DD = 8;
    localparam int AW = 19;
    localparam int DW = 10;
    localparam int EW = 1 + AW + DD;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] img_n = '0;
    logic [DW-1:0] blk_m = '0;
    logic [DD-1:0] Pixel_Data = '0;
    logic          new_pixel = 1'b0;
    logic          done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DD-1:0] wr_data;
    logic          blk_done;
    logic          frame_done;
    logic          err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    block_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .img_n      (img_n),
        .blk_m      (blk_m),
        .Pixel_Data (Pixel_Data),
        .new_pixel  (new_pixel),
        .done       (done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blk_done   (blk_done),
        .frame_done (frame_done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    int            tests_run = 0;
    int            tests_failed = 0;

    // Hand-computed write addresses for N=6, M=3 in block order.
    int tbl6[36] = '{ 0,  1,  2,  6,  7,  8, 12, 13, 14,
                      3,  4,  5,  9, 10, 11, 15, 16, 17,
                     18, 19, 20, 24, 25, 26, 30, 31, 32,
                     21, 22, 23, 27, 28, 29, 33, 34, 35};

    // Reference address of the k-th pixel of a frame in block-raster order.
    function automatic int model_addr(input int k, input int n, input int m);
        int bpr, blk, inb;
        bpr = n / m;
        blk = k / (m * m);
        inb = k % (m * m);
        return ((blk / bpr) * m + inb / m) * n + (blk % bpr) * m + inb % m;
    endfunction

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write got addr=%0d data=%0d blk_done=%0b expected no write",
                             wr_addr, wr_data, blk_done);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({blk_done, wr_addr, wr_data} !== exp_e) begin
                        tests_failed++;
                        $display("FAIL write got blk_done=%0b addr=%0d data=%0d expected blk_done=%0b addr=%0d data=%0d",
                                 blk_done, wr_addr, wr_data, exp_e[EW-1], exp_e[EW-2:DD], exp_e[DD-1:0]);
                    end
                end
            end else if (blk_done) begin
                tests_run++;
                tests_failed++;
                $display("FAIL blk_done_alone got blk_done=1 without wr_en expected 0");
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int act, input int expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input int d, input int addr, input bit blk, input bit with_done);
        logic [DD-1:0] dv;
        logic [AW-1:0] av;
        dv = d[DD-1:0];
        av = addr[AW-1:0];
        exp_q.push_back({blk, av, dv});
        Pixel_Data = dv;
        new_pixel  = 1'b1;
        done       = with_done;
        tick();
        new_pixel  = 1'b0;
        done       = 1'b0;
    endtask

    // A pixel that must not be written.
    task automatic stray_pixel(input int d);
        Pixel_Data = d[DD-1:0];
        new_pixel  = 1'b1;
        tick();
        new_pixel  = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic cfg_pulse(input int n, input int m);
        img_n    = n[DW-1:0];
        blk_m    = m[DW-1:0];
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic configure(input int n, input int m);
        int k;
        cfg_pulse(n, m);
        k = 0;
        while (dbg_state != 2'd2 && k < 1200) begin
            tick();
            k++;
        end
        chk("cfg_reaches_run", dbg_state, 2);
    endtask

    task automatic configure_bad(input int n, input int m);
        int k;
        cfg_pulse(n, m);
        k = 0;
        while (dbg_state != 2'd0 && k < 1200) begin
            tick();
            k++;
        end
        chk("bad_cfg_state_idle", dbg_state, 0);
        chk("bad_cfg_err", err, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        chk("writes_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b1;
        idle(2);

        // N=4, M=1: back-to-back pixels, sequential addresses, blk_done each.
        configure(4, 1);
        for (int i = 0; i < 16; i++) pix(100 + i, i, 1'b1, 1'b0);
        drain();
        chk("m1_err", err, 0);
        chk("m1_frame_done", frame_done, 1);
        chk("m1_state_full", dbg_state, 3);

        // N=6, M=3 full frame with legal done at block boundaries.
        configure(6, 3);
        chk("cfg_clears_frame_done", frame_done, 0);
        for (int i = 0; i < 36; i++) begin
            pix(i, tbl6[i], (i % 9) == 8, i == 17);
            if (i == 8) pulse_done();
            if (i == 34) begin
                idle(1);
                chk("frame_done_before_last", frame_done, 0);
            end
        end
        drain();
        chk("f6_err", err, 0);
        chk("f6_frame_done", frame_done, 1);
        chk("f6_last_addr", wr_addr, 35);
        chk("f6_last_data", wr_data, 35);

        // 37th pixel after a full frame: no write, error.
        stray_pixel(8'h77);
        idle(2);
        chk("overrun_err", err, 1);
        chk("overrun_frame_done", frame_done, 1);

        // Reload clears err/frame_done; early done sets sticky err.
        configure(6, 3);
        chk("reload_err", err, 0);
        chk("reload_frame_done", frame_done, 0);
        for (int i = 0; i < 5; i++) pix(200 + i, tbl6[i], 1'b0, 1'b0);
        pulse_done();
        chk("early_done_err", err, 1);
        for (int i = 5; i < 20; i++) pix(200 + i, tbl6[i], (i % 9) == 8, 1'b0);
        drain();
        chk("err_sticky", err, 1);

        // Asynchronous reset mid-frame, away from the clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_blk_done", blk_done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_state", dbg_state, 0);
        tick();
        rst = 1'b1;
        stray_pixel(8'h55);
        idle(3);
        chk("idle_pixel_state", dbg_state, 0);
        chk("idle_pixel_err", err, 0);

        // Configuration errors.
        configure_bad(1000, 10);
        configure_bad(6, 4);

        // N=720, M=72: first block plus first row of the second block.
        configure(720, 72);
        chk("f720_err_clear", err, 0);
        for (int k = 0; k < 5184 + 72; k++) pix(k, model_addr(k, 720, 72), (k % 5184) == 5183, 1'b0);
        drain();
        chk("f720_last_addr", wr_addr, 143);
        chk("f720_err", err, 0);
        chk("f720_frame_done", frame_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL timeout got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end

endmodule
